// File: rtl/useq_pkg.sv
// useq_pkg: shared constants for the micro-sequencer.
// Class codes, state encoding, IR field positions.
package useq_pkg;

  localparam int WIDTH = 16;
  localparam logic [2:0] PC_REG_DEF = 3'd7;

  localparam int CLS_LSB = 13;
  localparam int ALU_LSB = 9;
  localparam int OP2_LSB = 6;
  localparam int OP1_LSB = 3;
  localparam int OP0_LSB = 0;

  localparam logic [2:0] CLS_NOP  = 3'b000;
  localparam logic [2:0] CLS_ALU  = 3'b001;
  localparam logic [2:0] CLS_MOV  = 3'b010;
  localparam logic [2:0] CLS_HALT = 3'b111;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_INCPC  = 3'd1;
  localparam logic [2:0] ST_EXEC1  = 3'd2;
  localparam logic [2:0] ST_EXEC2  = 3'd3;
  localparam logic [2:0] ST_EXEC3  = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  typedef struct packed {
    logic nop;
    logic alu;
    logic mov;
    logic halt;
    logic illegal;
  } cls_t;

  // Class code to one-hot flags; unknown codes are illegal.
  function automatic cls_t cls_of(input logic [2:0] code);
    cls_t c;
    c = '0;
    case (code)
      CLS_NOP:  c.nop = 1'b1;
      CLS_ALU:  c.alu = 1'b1;
      CLS_MOV:  c.mov = 1'b1;
      CLS_HALT: c.halt = 1'b1;
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/useq_decode.sv
// useq_decode: instruction register to class
// flags and operand fields, purely combinational.
module useq_decode
  import useq_pkg::*;
(
  input  logic [WIDTH-1:0] ir,
  output cls_t             cls,
  output logic [3:0]       alu_op,
  output logic [2:0]       op0,
  output logic [2:0]       op1,
  output logic [2:0]       op2
);

  assign cls    = cls_of(ir[CLS_LSB +: 3]);
  assign alu_op = ir[ALU_LSB +: 4];
  assign op2    = ir[OP2_LSB +: 3];
  assign op1    = ir[OP1_LSB +: 3];
  assign op0    = ir[OP0_LSB +: 3];

endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: fetch/exec micro-sequencer driving
// the register selector and ALU strobes.
module useq_ctrl
  import useq_pkg::*;
#(
  parameter logic [2:0] PC_REG = PC_REG_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  output logic             memReq,
  input  logic             memAck,
  input  logic [WIDTH-1:0] memData,
  output logic             oe,
  output logic             load,
  output logic [1:0]       oeSourceSel,
  output logic             loadSourceSel,
  output logic [2:0]       useqRegSelOe,
  output logic [2:0]       useqRegSelLoad,
  output logic [2:0]       op0,
  output logic [2:0]       op1,
  output logic [2:0]       op2,
  output logic [3:0]       aluOp,
  output logic             aluLatchA,
  output logic             aluLatchB,
  output logic             pcInc,
  output logic             halted,
  output logic             illegal
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WIDTH-1:0] ir;
  cls_t             cls;
  logic             accept;

  useq_decode u_dec (
    .ir     (ir),
    .cls    (cls),
    .alu_op (aluOp),
    .op0    (op0),
    .op1    (op1),
    .op2    (op2)
  );

  assign accept = (state == ST_FETCH) && memAck && !stall;

  // State and IR; stall freezes both.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      if (accept) ir <= memData;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (memAck) state_nxt = ST_INCPC;
      ST_INCPC: begin
        unique case (1'b1)
          cls.halt:        state_nxt = ST_HALTED;
          cls.alu,
          cls.mov:         state_nxt = ST_EXEC1;
          cls.nop,
          cls.illegal:     state_nxt = ST_FETCH;
          default:         state_nxt = ST_FETCH;
        endcase
      end
      ST_EXEC1:  state_nxt = cls.alu ? ST_EXEC2 : ST_FETCH;
      ST_EXEC2:  state_nxt = ST_EXEC3;
      ST_EXEC3:  state_nxt = ST_FETCH;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // Moore outputs, then reset and stall gating.
  always_comb begin
    memReq         = 1'b0;
    oe             = 1'b0;
    load           = 1'b0;
    oeSourceSel    = 2'd0;
    loadSourceSel  = 1'b0;
    useqRegSelOe   = 3'd0;
    useqRegSelLoad = 3'd0;
    aluLatchA      = 1'b0;
    aluLatchB      = 1'b0;
    pcInc          = 1'b0;
    halted         = 1'b0;
    illegal        = 1'b0;
    case (state)
      ST_FETCH: begin
        memReq       = 1'b1;
        oe           = 1'b1;
        useqRegSelOe = PC_REG;
      end
      ST_INCPC: begin
        oe             = 1'b1;
        useqRegSelOe   = PC_REG;
        pcInc          = 1'b1;
        load           = 1'b1;
        useqRegSelLoad = PC_REG;
        illegal        = cls.illegal;
      end
      ST_EXEC1: begin
        if (cls.alu) begin
          oe          = 1'b1;
          oeSourceSel = 2'd2;
          aluLatchA   = 1'b1;
        end else if (cls.mov) begin
          oe            = 1'b1;
          oeSourceSel   = 2'd2;
          load          = 1'b1;
          loadSourceSel = 1'b1;
        end
      end
      ST_EXEC2: begin
        oe          = 1'b1;
        oeSourceSel = 2'd3;
        aluLatchB   = 1'b1;
      end
      ST_EXEC3: begin
        load          = 1'b1;
        loadSourceSel = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
    if (stall) load = 1'b0;
    if (reset) begin
      memReq    = 1'b0;
      oe        = 1'b0;
      load      = 1'b0;
      pcInc     = 1'b0;
      aluLatchA = 1'b0;
      aluLatchB = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule
